// File: rtl/call_return_sequencer.sv
// Program-counter sequencer for the LEG CPU; sole driver of the downstream hardware return stack.
// Latency: stack strobes combinational in the CALL/RET cycle; new PC/DEPTH visible one cycle later.
// Backpressure: EN=0 holds all state and suppresses strobes; a trap freezes everything until rst.
// Optional build macro CALL_RETURN_GUARD_EN enables overflow/underflow depth checks.
module call_return_sequencer #(
    parameter  int PC_WIDTH    = 8,
    parameter  int STEP        = 4,
    parameter  int STACK_DEPTH = 256,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                EN,
    input  logic                CALL,
    input  logic                RET,
    input  logic                JUMP,
    input  logic [PC_WIDTH-1:0] TARGET,
    input  logic [PC_WIDTH-1:0] STACK_OUTPUT,
    output logic [PC_WIDTH-1:0] PC,
    output logic                STACK_PUSH,
    output logic                STACK_POP,
    output logic [PC_WIDTH-1:0] STACK_VALUE,
    output logic [DEPTH_W-1:0]  DEPTH,
    output logic                FAULT,
    output logic [1:0]          FAULT_CODE
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_OVERFLOW  = 2'd1;
    localparam logic [1:0] FC_UNDERFLOW = 2'd2;
    localparam logic [1:0] FC_CALL_RET  = 2'd3;

    localparam logic [PC_WIDTH-1:0] STEP_V = PC_WIDTH'(STEP);
    localparam logic [DEPTH_W-1:0]  FULL_V = DEPTH_W'(STACK_DEPTH);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                fault_q, fault_d;
    logic [1:0]          fault_code_q, fault_code_d;

    logic                stack_push;
    logic                stack_pop;
    logic [PC_WIDTH-1:0] pc_next_seq;
    logic                stack_full;
    logic                stack_empty;
    logic                advance;

    // Sequential return address; wraps naturally at the PC width.
    assign pc_next_seq = pc_q + STEP_V;

    // Only an enabled, running, non-reset cycle may act on the control inputs.
    assign advance = !rst && (state_q == ST_RUN) && EN;

`ifdef CALL_RETURN_GUARD_EN
    // Depth checks trap before the stack can be overrun or underrun.
    assign stack_full  = (depth_q == FULL_V);
    assign stack_empty = (depth_q == '0);
`else
    // Unguarded build: the stack is trusted, DEPTH simply wraps.
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b0;
`endif

    // Next-state decode: one action per cycle in CALL&RET > RET > CALL > JUMP > step priority.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        depth_d      = depth_q;
        fault_code_d = fault_code_q;
        stack_push   = 1'b0;
        stack_pop    = 1'b0;

        if (advance) begin
            if (CALL && RET) begin
                state_d      = ST_TRAP;
                fault_code_d = FC_CALL_RET;
            end else if (RET) begin
                if (stack_empty) begin
                    state_d      = ST_TRAP;
                    fault_code_d = FC_UNDERFLOW;
                end else begin
                    stack_pop = 1'b1;
                    pc_d      = STACK_OUTPUT;
                    depth_d   = depth_q - 1'b1;
                end
            end else if (CALL) begin
                // JUMP is deliberately ignored here: CALL already loads TARGET.
                if (stack_full) begin
                    state_d      = ST_TRAP;
                    fault_code_d = FC_OVERFLOW;
                end else begin
                    stack_push = 1'b1;
                    pc_d       = TARGET;
                    depth_d    = depth_q + 1'b1;
                end
            end else if (JUMP) begin
                pc_d = TARGET;
            end else begin
                pc_d = pc_next_seq;
            end
        end

        fault_d = (state_d == ST_TRAP);
    end

    // FSM and all architectural state; synchronous reset returns to RUN at PC 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= '0;
            depth_q      <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            depth_q      <= depth_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign PC          = pc_q;
    assign DEPTH       = depth_q;
    assign FAULT       = fault_q;
    assign FAULT_CODE  = fault_code_q;
    assign STACK_PUSH  = stack_push;
    assign STACK_POP   = stack_pop;
    assign STACK_VALUE = pc_next_seq;

endmodule

// File: tb/tb_call_return_sequencer.sv
// Directed bench for call_return_sequencer: step, call/return, traps, wrap and enable gating.
// Inputs change 1 time unit after the rising edge; strobes are checked before the next edge.
// Registered outputs are checked 1 time unit after the edge that loads them.
module tb_call_return_sequencer;

    logic       clk;
    logic       rst;
    logic       EN;
    logic       CALL;
    logic       RET;
    logic       JUMP;
    logic [7:0] TARGET;
    logic [7:0] STACK_OUTPUT;
    logic [7:0] PC;
    logic       STACK_PUSH;
    logic       STACK_POP;
    logic [7:0] STACK_VALUE;
    logic [8:0] DEPTH;
    logic       FAULT;
    logic [1:0] FAULT_CODE;

    int passed = 0;
    int total  = 0;
    int pushes = 0;

    call_return_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .EN           (EN),
        .CALL         (CALL),
        .RET          (RET),
        .JUMP         (JUMP),
        .TARGET       (TARGET),
        .STACK_OUTPUT (STACK_OUTPUT),
        .PC           (PC),
        .STACK_PUSH   (STACK_PUSH),
        .STACK_POP    (STACK_POP),
        .STACK_VALUE  (STACK_VALUE),
        .DEPTH        (DEPTH),
        .FAULT        (FAULT),
        .FAULT_CODE   (FAULT_CODE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        CALL = 1'b0;
        RET  = 1'b0;
        JUMP = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_ctl();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; EN = 1'b1; CALL = 1'b1; RET = 1'b0; JUMP = 1'b0;
        TARGET = 8'h40; STACK_OUTPUT = 8'h00;

        // Reset cycle suppresses a pending CALL strobe.
        #1;
        check("rst_no_push", STACK_PUSH, 1'b0);
        check("rst_no_pop", STACK_POP, 1'b0);
        cyc();
        check("rst_no_push2", STACK_PUSH, 1'b0);
        cyc();
        rst = 1'b0; clear_ctl();
        #1;
        check("rst_pc", PC, 8'h00);
        check("rst_depth", DEPTH, 9'd0);
        check("rst_fault", FAULT, 1'b0);
        check("rst_code", FAULT_CODE, 2'd0);
        check("rst_value", STACK_VALUE, 8'h04);

        // Plain stepping.
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("step_push", STACK_PUSH, 1'b0);
            check("step_pop", STACK_POP, 1'b0);
            cyc();
            check("step_pc", PC, 32'(4 * i));
        end

        // CALL at 0x10 to 0x40.
        CALL = 1'b1; TARGET = 8'h40;
        #1;
        check("call_push", STACK_PUSH, 1'b1);
        check("call_pop", STACK_POP, 1'b0);
        check("call_value", STACK_VALUE, 8'h14);
        cyc();
        clear_ctl();
        check("call_pc", PC, 8'h40);
        check("call_depth", DEPTH, 9'd1);

        // RET back to 0x14.
        RET = 1'b1; STACK_OUTPUT = 8'h14;
        #1;
        check("ret_pop", STACK_POP, 1'b1);
        check("ret_push", STACK_PUSH, 1'b0);
        cyc();
        clear_ctl();
        check("ret_pc", PC, 8'h14);
        check("ret_depth", DEPTH, 9'd0);

        // Back-to-back CALL then RET.
        CALL = 1'b1; JUMP = 1'b1; TARGET = 8'h80;
        #1;
        check("b2b_push", STACK_PUSH, 1'b1);
        check("b2b_value", STACK_VALUE, 8'h18);
        cyc();
        clear_ctl();
        RET = 1'b1; STACK_OUTPUT = 8'h18;
        check("b2b_call_pc", PC, 8'h80);
        check("b2b_call_depth", DEPTH, 9'd1);
        #1;
        check("b2b_pop", STACK_POP, 1'b1);
        cyc();
        clear_ctl();
        check("b2b_ret_pc", PC, 8'h18);
        check("b2b_ret_depth", DEPTH, 9'd0);

        // JUMP to 0xFC, then wrap.
        JUMP = 1'b1; TARGET = 8'hFC;
        #1;
        check("jump_no_push", STACK_PUSH, 1'b0);
        cyc();
        clear_ctl();
        check("jump_pc", PC, 8'hFC);
        check("wrap_value", STACK_VALUE, 8'h00);
        cyc();
        check("wrap_pc", PC, 8'h00);

        // EN=0 ignores CALL.
        EN = 1'b0; CALL = 1'b1; TARGET = 8'h40;
        #1;
        check("en0_push", STACK_PUSH, 1'b0);
        cyc();
        check("en0_pc", PC, 8'h00);
        check("en0_depth", DEPTH, 9'd0);
        EN = 1'b1; clear_ctl();

        // RET at empty.
        do_reset();
        RET = 1'b1; STACK_OUTPUT = 8'h55;
`ifdef CALL_RETURN_GUARD_EN
        #1;
        check("uf_no_pop", STACK_POP, 1'b0);
        cyc();
        clear_ctl();
        check("uf_fault", FAULT, 1'b1);
        check("uf_code", FAULT_CODE, 2'd2);
        check("uf_pc", PC, 8'h00);
        CALL = 1'b1; JUMP = 1'b1; TARGET = 8'h33;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("trap_no_push", STACK_PUSH, 1'b0);
            cyc();
            check("trap_pc", PC, 8'h00);
            check("trap_code", FAULT_CODE, 2'd2);
        end
        do_reset();
        check("uf_rst_pc", PC, 8'h00);
        check("uf_rst_fault", FAULT, 1'b0);
        check("uf_rst_code", FAULT_CODE, 2'd0);
`else
        #1;
        check("uf_pop", STACK_POP, 1'b1);
        cyc();
        clear_ctl();
        check("uf_fault", FAULT, 1'b0);
        check("uf_pc", PC, 8'h55);
        check("uf_depth", DEPTH, 9'h1FF);
        do_reset();
        check("uf_rst_pc", PC, 8'h00);
        check("uf_rst_depth", DEPTH, 9'd0);
`endif

        // CALL, RET and JUMP together.
        CALL = 1'b1; RET = 1'b1; JUMP = 1'b1; TARGET = 8'h20; STACK_OUTPUT = 8'h30;
        #1;
        check("cr_no_push", STACK_PUSH, 1'b0);
        check("cr_no_pop", STACK_POP, 1'b0);
        cyc();
        clear_ctl();
        check("cr_fault", FAULT, 1'b1);
        check("cr_code", FAULT_CODE, 2'd3);
        check("cr_pc", PC, 8'h00);
        check("cr_depth", DEPTH, 9'd0);
        cyc();
        check("cr_pc_frozen", PC, 8'h00);
        do_reset();

        // Fill the stack, then one more CALL.
        CALL = 1'b1; TARGET = 8'h40;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (STACK_PUSH === 1'b1) pushes++;
            cyc();
        end
        check("fill_pushes", pushes, 256);
        check("fill_depth", DEPTH, 9'd256);
        check("fill_fault", FAULT, 1'b0);
        #1;
`ifdef CALL_RETURN_GUARD_EN
        check("of_no_push", STACK_PUSH, 1'b0);
        cyc();
        clear_ctl();
        check("of_fault", FAULT, 1'b1);
        check("of_code", FAULT_CODE, 2'd1);
        check("of_depth", DEPTH, 9'd256);
        check("of_pc", PC, 8'h40);
`else
        check("of_push", STACK_PUSH, 1'b1);
        cyc();
        clear_ctl();
        check("of_fault", FAULT, 1'b0);
        check("of_depth", DEPTH, 9'd257);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/call_return_sequencer.md
Name: call_return_sequencer

Overview:
- Program-counter sequencer for the LEG CPU. Sits directly upstream of the 8-bit hardware stack and is its only driver.
- Advances the PC and takes jumps.
- On CALL it pushes the return address into the stack. On RET it pops the stack into the PC.
- Tracks stack depth and traps overflow and underflow.

Parameters:
PC_WIDTH, 8, width of PC, TARGET and stack data.
STEP, 4, PC increment per instruction (LEG instructions are 4 bytes).
STACK_DEPTH, 256, number of entries in the downstream stack.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
EN  input  1  advance enable; 0 = hold all state, no stack strobes.
CALL  input  1  call: push return address, PC <= TARGET.
RET  input  1  return: pop stack, PC <= STACK_OUTPUT.
JUMP  input  1  unconditional jump: PC <= TARGET.
TARGET  input  PC_WIDTH  call/jump destination.
STACK_OUTPUT  input  PC_WIDTH  stack pop data; valid combinationally in the same cycle as STACK_POP.
PC  output  PC_WIDTH  current program counter (registered).
STACK_PUSH  output  1  push strobe to the stack (combinational, one cycle per call).
STACK_POP  output  1  pop strobe to the stack (combinational, one cycle per return).
STACK_VALUE  output  PC_WIDTH  data to push = PC + STEP, mod 2^PC_WIDTH.
DEPTH  output  clog2(STACK_DEPTH)+1  current number of entries pushed.
FAULT  output  1  sticky trap flag.
FAULT_CODE  output  2  fault codes: 0 none, 1 overflow, 2 underflow, 3 CALL and RET asserted together.

Behaviour:
- State machine with two states, RUN and TRAP.
- Reset:
  - PC=0, DEPTH=0, state RUN, FAULT=0, FAULT_CODE=0.
  - STACK_PUSH and STACK_POP are 0 during the reset cycle.
  - Reset mid-operation discards any strobe in that cycle; the stack's own pointer is reset by the same rst.
- RUN with EN=1: exactly one action per cycle, selected in this priority order:
  1. CALL & RET together:
     - Enter TRAP with code 3.
     - No strobes; PC and DEPTH unchanged.
  2. RET:
     - If DEPTH==0: enter TRAP with code 2, no pop.
     - Else: STACK_POP=1; next PC = STACK_OUTPUT; DEPTH-1.
  3. CALL:
     - If DEPTH==STACK_DEPTH: enter TRAP with code 1, no push.
     - Else: STACK_PUSH=1; STACK_VALUE = PC+STEP; next PC = TARGET; DEPTH+1.
     - JUMP is ignored when CALL is asserted.
  4. JUMP: next PC = TARGET.
  5. Otherwise: next PC = PC+STEP, wrapping mod 2^PC_WIDTH (e.g. 0xFC -> 0x00).
- RUN with EN=0:
  - PC and DEPTH hold.
  - STACK_PUSH=STACK_POP=0.
  - Control inputs are ignored.
- STACK_VALUE is always driven to PC+STEP, even when STACK_PUSH=0.
- TRAP state:
  - PC and DEPTH frozen; strobes forced 0.
  - FAULT=1; FAULT_CODE holds the first fault.
  - Leaves TRAP only on rst.
- Latency:
  - Strobes are asserted in the same cycle as CALL/RET.
  - New PC is visible the cycle after.
- Back-to-back RET then CALL (or the reverse) in consecutive cycles is legal; each completes in one cycle.
- DEPTH never wraps while in RUN.

Optional Feature:
- Macro: CALL_RETURN_GUARD_EN.
- Defined:
  - Overflow and underflow checks active as described in Behaviour.
- Undefined:
  - No depth checks.
  - CALL at full still pushes; DEPTH wraps modulo 2^width of DEPTH.
  - RET at empty still pops; DEPTH wraps to all-ones.
  - The CALL&RET fault (code 3) and the TRAP state remain in both builds.

Test Plan:
- Reset, EN=1 for 4 cycles, no controls -> PC = 0x00, 0x04, 0x08, 0x0C, 0x10; strobes stay 0.
- At PC=0x10, CALL=1 with TARGET=0x40 -> same cycle STACK_PUSH=1, STACK_VALUE=0x14; next cycle PC=0x40, DEPTH=1.
- From the CALL state (PC=0x40, DEPTH=1), RET=1 with STACK_OUTPUT=0x14 -> same cycle STACK_POP=1; next PC=0x14, DEPTH=0.
- From reset, RET=1 -> FAULT=1, FAULT_CODE=2, no pop; PC frozen for 5 further cycles; rst clears to PC=0, FAULT=0.
- CALL=RET=JUMP=1 -> FAULT_CODE=3, no strobes. Separately, 256 CALLs followed by one more CALL -> FAULT_CODE=1, DEPTH=256, no 257th push (guard build).
- PC at 0xFC with EN=1 -> PC=0x00. Separately, EN=0 with CALL=1 -> no push, PC unchanged.
